// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides.
// Non-multiply ops complete in one cycle; multiply is a WIDTH-iteration
// shift-add sequence followed by one cycle to register the result.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_carry;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   shr_full;
  logic [WIDTH-1:0] sh;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign out_valid = (state == DONE);

  // Handshake and next-state logic
  always_comb begin
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    accept     = in_valid && in_ready;
    is_mul     = MUL_ENABLE && (mode == 3'b110);
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? MUL : DONE;
      MUL:  if (count == CW'(WIDTH)) state_next = DONE;
      DONE: begin
        if (accept)         state_next = is_mul ? MUL : DONE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle result and flags for every mode except the sequential multiply.
  // Shift-right pads a zero below in1 so the bit shifted out last lands in bit 0.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    wide      = '0;
    sh        = WIDTH'(in2 % WIDTH);
    shr_full  = {in1, 1'b0} >> sh;
    case (mode)
      3'b000: begin
        wide      = {1'b0, in1} + {1'b0, in2};
        alu_out   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      3'b001, 3'b010: begin
        wide      = {1'b0, in1} - {1'b0, in2};
        alu_out   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      3'b011: alu_out = in1 & in2;
      3'b100: alu_out = in1 | in2;
      3'b101: alu_out = in1 ^ in2;
      3'b110: alu_out = '0;
      3'b111: begin
        alu_out   = shr_full[WIDTH:1];
        alu_carry = shr_full[0];
      end
      default: alu_out = '0;
    endcase
    alu_zero = (mode == 3'b010) ? (in1 == in2) : (alu_out == '0);
  end

  // State, result/flag registers and multiply datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out        <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (is_mul) begin
          mcand  <= (2*WIDTH)'(in1);
          mplier <= in2;
          acc    <= '0;
          count  <= '0;
        end else begin
          out        <= alu_out;
          flag_zero  <= alu_zero;
          flag_carry <= alu_carry;
        end
      end
      if (state == MUL) begin
        if (count == CW'(WIDTH)) begin
          out        <= acc[WIDTH-1:0];
          flag_carry <= |acc[2*WIDTH-1:WIDTH];
          flag_zero  <= (acc[WIDTH-1:0] == '0);
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8, multiply enabled).
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [2:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       flag_zero;
  logic       flag_carry;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Present one operation while the DUT is idle; returns #1 after the accept edge
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    @(negedge clk);
    in1 = a; in2 = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (dout !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", dout); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {flag_zero, flag_carry}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    apply(8'd200, 8'd100, 3'b000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid got %b expected 1", out_valid); end
    checks++; if (dout !== 8'd44) begin errors++; $display("FAIL add_out: got %0d expected 44", dout); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL add_flags: got %b expected 01", {flag_zero, flag_carry}); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consume_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_consume_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_sub_cmp();
    apply(8'd5, 8'd5, 3'b001);
    checks++; if (dout !== 8'd0) begin errors++; $display("FAIL sub_out: got %0d expected 0", dout); end
    checks++; if ({flag_zero, flag_carry} !== 2'b10) begin errors++; $display("FAIL sub_flags: got %b expected 10", {flag_zero, flag_carry}); end
    consume();
    apply(8'd3, 8'd7, 3'b010);
    checks++; if (dout !== 8'd252) begin errors++; $display("FAIL cmp_out: got %0d expected 252", dout); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL cmp_flags: got %b expected 01", {flag_zero, flag_carry}); end
    consume();
    apply(8'd9, 8'd9, 3'b010);
    checks++; if ({dout, flag_zero, flag_carry} !== {8'd0, 2'b10}) begin errors++; $display("FAIL cmp_equal: got %0d/%b expected 0/10", dout, {flag_zero, flag_carry}); end
    consume();
  endtask

  task automatic test_logic();
    apply(8'hF0, 8'h3C, 3'b011);
    checks++; if ({dout, flag_zero, flag_carry} !== {8'h30, 2'b00}) begin errors++; $display("FAIL and: got %h/%b expected 30/00", dout, {flag_zero, flag_carry}); end
    consume();
    apply(8'hF0, 8'h3C, 3'b100);
    checks++; if ({dout, flag_zero, flag_carry} !== {8'hFC, 2'b00}) begin errors++; $display("FAIL or: got %h/%b expected fc/00", dout, {flag_zero, flag_carry}); end
    consume();
    apply(8'hF0, 8'h3C, 3'b101);
    checks++; if ({dout, flag_zero, flag_carry} !== {8'hCC, 2'b00}) begin errors++; $display("FAIL xor: got %h/%b expected cc/00", dout, {flag_zero, flag_carry}); end
    consume();
  endtask

  task automatic test_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_out, input logic exp_z, input logic exp_c);
    int cycles;
    apply(a, b, 3'b110);
    cycles = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready: got %b expected 0", in_ready); end
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++; if (cycles !== 9) begin errors++; $display("FAIL mul_latency: got %0d cycles expected 9", cycles); end
    checks++; if (dout !== exp_out) begin errors++; $display("FAIL mul_out: got %0d expected %0d", dout, exp_out); end
    checks++; if ({flag_zero, flag_carry} !== {exp_z, exp_c}) begin errors++; $display("FAIL mul_flags: got %b expected %b", {flag_zero, flag_carry}, {exp_z, exp_c}); end
    consume();
  endtask

  task automatic test_shr();
    apply(8'h81, 8'd1, 3'b111);
    checks++; if ({dout, flag_carry} !== {8'h40, 1'b1}) begin errors++; $display("FAIL shr_1: got %h/%b expected 40/1", dout, flag_carry); end
    consume();
    apply(8'hA5, 8'd8, 3'b111);
    checks++; if ({dout, flag_zero, flag_carry} !== {8'hA5, 2'b00}) begin errors++; $display("FAIL shr_mod0: got %h/%b expected a5/00", dout, {flag_zero, flag_carry}); end
    consume();
    apply(8'hFF, 8'd15, 3'b111);
    checks++; if ({dout, flag_carry} !== {8'h01, 1'b1}) begin errors++; $display("FAIL shr_7: got %h/%b expected 01/1", dout, flag_carry); end
    consume();
  endtask

  task automatic test_back_to_back();
    apply(8'd1, 8'd2, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, dout, flag_zero, flag_carry} !== {2'b10, 8'd3, 2'b00})
        begin errors++; $display("FAIL hold_%0d: got v=%b r=%b out=%0d f=%b expected v=1 r=0 out=3 f=00", i, out_valid, in_ready, dout, {flag_zero, flag_carry}); end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in1 = 8'd10; in2 = 8'd20; mode = 3'b000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    checks++; if ({out_valid, dout} !== {1'b1, 8'd30}) begin errors++; $display("FAIL b2b_add: got v=%b out=%0d expected v=1 out=30", out_valid, dout); end
    @(negedge clk);
    in1 = 8'h0F; in2 = 8'h0F; mode = 3'b101;
    @(posedge clk); #1;
    checks++; if ({out_valid, dout, flag_zero, flag_carry} !== {1'b1, 8'd0, 2'b10}) begin errors++; $display("FAIL b2b_xor: got v=%b out=%0d f=%b expected v=1 out=0 f=10", out_valid, dout, {flag_zero, flag_carry}); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if ({dout, flag_zero, flag_carry} !== {8'd0, 2'b10}) begin errors++; $display("FAIL flags_retained: got %0d/%b expected 0/10", dout, {flag_zero, flag_carry}); end
  endtask

  task automatic test_reset_in_mul();
    apply(8'd200, 8'd100, 3'b000);
    consume();
    apply(8'd15, 8'd17, 3'b110);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL mulrst_handshake: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
    checks++; if ({dout, flag_zero, flag_carry} !== {8'd0, 2'b00}) begin errors++; $display("FAIL mulrst_regs: got %0d/%b expected 0/00", dout, {flag_zero, flag_carry}); end
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mulrst_no_pulse: got %0d valid cycles expected 0", seen); end
    end
    apply(8'd1, 8'd1, 3'b000);
    checks++; if ({out_valid, dout} !== {1'b1, 8'd2}) begin errors++; $display("FAIL mulrst_next_op: got v=%b out=%0d expected v=1 out=2", out_valid, dout); end
    consume();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; mode = '0;
    test_reset();
    test_add();
    test_sub_cmp();
    test_logic();
    test_mul(8'd15, 8'd17, 8'd255, 1'b0, 1'b0);
    test_mul(8'd16, 8'd16, 8'd0, 1'b1, 1'b1);
    test_shr();
    test_back_to_back();
    test_reset_in_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
